// File: rtl/aes_pkg.sv
// Shared constants and types for the round-key store and sequencer.
package aes_pkg;

  localparam int unsigned KEY_W       = 128;
  localparam int unsigned NUM_ROUNDS  = 10;
  localparam int unsigned ROUND_IDX_W = 4;

  localparam logic [ROUND_IDX_W-1:0] KEY_ADDR_NONE = '0;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/round_key_sequencer_if.sv
// Round-key stream handshake: master presents keys, slave accepts with rk_ready.
interface round_key_sequencer_if #(
  parameter int unsigned KEY_W = aes_pkg::KEY_W
);
  logic                               rk_valid;
  logic                               rk_ready;
  logic [KEY_W-1:0]                   rk_data;
  logic [aes_pkg::ROUND_IDX_W-1:0]    rk_round;
  logic                               rk_last;

  modport master (
    output rk_valid, rk_data, rk_round, rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk_valid, rk_data, rk_round, rk_last,
    output rk_ready
  );
endinterface

// File: rtl/round_key_sequencer_rk_regfile.sv
// Round-key storage: addressed write port, combinational read port, not reset.
module rk_regfile
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W = KEY_W,
  parameter int unsigned DEPTH  = NUM_ROUNDS + 1
) (
  input  logic                   clk,
  input  logic                   i_k0_we,
  input  logic [DATA_W-1:0]      i_k0_data,
  input  logic                   i_we,
  input  logic [ROUND_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]      i_wdata,
  input  logic [ROUND_IDX_W-1:0] i_raddr,
  output logic [DATA_W-1:0]      o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Entry 0 has its own load path so a cipher key and an expansion write can land together.
  always_ff @(posedge clk) begin
    if (i_we)    r_mem[i_waddr] <= i_wdata;
    if (i_k0_we) r_mem[0]       <= i_k0_data;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/round_key_sequencer.sv
// Captures the key schedule as it is expanded and streams it to the cipher datapath.
module round_key_sequencer #(
  parameter int unsigned KEY_W      = aes_pkg::KEY_W,
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_in_valid,
  input  logic [KEY_W-1:0]           key_in,
  input  logic [KEY_W-1:0]           key_wr_data,
  input  logic [3:0]                 key_wr_addr,
  input  logic                       key_loaded,
  input  logic                       start,
  input  logic                       decrypt,
  round_key_sequencer_if.master      rk,
  output logic                       busy,
  output logic                       keys_ready,
  output logic                       done
);
  import aes_pkg::*;

  localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;
  localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(NUM_ROUNDS);

  state_t                 r_state, w_state_nxt;
  logic [ROUND_IDX_W-1:0] r_idx, w_idx_nxt;
  logic                   r_dec, w_dec_nxt;
  logic                   r_last, w_last_nxt;
  logic                   r_done, w_done_nxt;
  logic [KEY_W-1:0]       r_data;
  logic [NUM_KEYS-1:0]    r_valid, w_valid_nxt;
  logic                   r_loaded, w_loaded_nxt;
  logic                   r_keys_ready;
  logic                   w_cap, w_k0_we, w_wr_ok, w_load_beat;
  logic [KEY_W-1:0]       w_rd_data;

  assign w_cap   = (r_state != STREAM);
  assign w_k0_we = w_cap && key_in_valid;
  assign w_wr_ok = w_cap && (key_wr_addr != KEY_ADDR_NONE) && (key_wr_addr <= LAST_IDX);

  rk_regfile #(.DATA_W(KEY_W), .DEPTH(NUM_KEYS)) u_regfile (
    .clk      (clk),
    .i_k0_we  (w_k0_we),
    .i_k0_data(key_in),
    .i_we     (w_wr_ok),
    .i_waddr  (key_wr_addr),
    .i_wdata  (key_wr_data),
    .i_raddr  (w_idx_nxt),
    .o_rdata  (w_rd_data)
  );

  // A write in the same cycle as a new cipher key keeps its valid bit.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_k0_we) w_valid_nxt = NUM_KEYS'(1);
    if (w_wr_ok) w_valid_nxt[key_wr_addr] = 1'b1;
    w_loaded_nxt = w_k0_we ? 1'b0 : (r_loaded | (key_loaded & r_valid[0]));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dec_nxt   = r_dec;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;
    w_load_beat = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && r_keys_ready) begin
          w_state_nxt = STREAM;
          w_dec_nxt   = decrypt;
          w_idx_nxt   = decrypt ? LAST_IDX : '0;
          w_load_beat = 1'b1;
        end
      end
      STREAM: begin
        if (rk.rk_ready) begin
          if (r_last) begin
            w_state_nxt = IDLE;
            w_last_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt   = r_dec ? r_idx - 1'b1 : r_idx + 1'b1;
            w_load_beat = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_load_beat)
      w_last_nxt = w_dec_nxt ? (w_idx_nxt == '0) : (w_idx_nxt == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_dec        <= 1'b0;
      r_last       <= 1'b0;
      r_done       <= 1'b0;
      r_data       <= '0;
      r_valid      <= '0;
      r_loaded     <= 1'b0;
      r_keys_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_dec        <= w_dec_nxt;
      r_last       <= w_last_nxt;
      r_done       <= w_done_nxt;
      r_valid      <= w_valid_nxt;
      r_loaded     <= w_loaded_nxt;
      r_keys_ready <= w_loaded_nxt & (&w_valid_nxt);
      if (w_load_beat) r_data <= w_rd_data;
    end
  end

  assign rk.rk_valid = (r_state == STREAM);
  assign rk.rk_data  = r_data;
  assign rk.rk_round = r_idx;
  assign rk.rk_last  = r_last;
  assign busy        = (r_state == STREAM);
  assign keys_ready  = r_keys_ready;
  assign done        = r_done;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed/randomized bench for round_key_sequencer against a key-schedule array model.
module tb_round_key_sequencer;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_in_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] key_wr_data = '0;
  logic [3:0]   key_wr_addr = '0;
  logic         key_loaded = 1'b0;
  logic         start = 1'b0;
  logic         decrypt = 1'b0;
  logic         busy, keys_ready, done;

  round_key_sequencer_if #(.KEY_W(KEY_W)) rk_bus ();

  round_key_sequencer #(.KEY_W(KEY_W), .NUM_ROUNDS(NUM_ROUNDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in_valid(key_in_valid),
    .key_in      (key_in),
    .key_wr_data (key_wr_data),
    .key_wr_addr (key_wr_addr),
    .key_loaded  (key_loaded),
    .start       (start),
    .decrypt     (decrypt),
    .rk          (rk_bus),
    .busy        (busy),
    .keys_ready  (keys_ready),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Reference schedule: what the consumer should hold, per entry.
  logic [127:0] m_key [11];
  logic [10:0]  m_valid = '0;
  bit           m_loaded = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  logic [127:0] fips [11];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One capture cycle outside a stream; model applies the schedule rules afterwards.
  task automatic cap(input bit kiv, input logic [127:0] k, input int addr,
                     input logic [127:0] d, input bit kl);
    bit v0;
    key_in_valid = kiv; key_in = k; key_wr_addr = 4'(addr); key_wr_data = d; key_loaded = kl;
    step();
    v0 = m_valid[0];
    if (kiv) begin m_key[0] = k; m_valid = 11'h001; m_loaded = 1'b0; end
    else if (kl && v0) m_loaded = 1'b1;
    if (addr >= 1 && addr <= 10) begin m_key[addr] = d; m_valid[addr] = 1'b1; end
    key_in_valid = 1'b0; key_wr_addr = '0; key_loaded = 1'b0;
    chk("keys_ready_after_capture", keys_ready, m_loaded && (m_valid == 11'h7FF));
  endtask

  // mode 0: ready tied high, 1: toggling 1,0,..., 2: random. Ends with done observed.
  task automatic run_stream(input bit dec, input int mode, input bit junk);
    int  e, cyc, term;
    bit  fin, tog, rdy;
    e = dec ? 10 : 0; term = dec ? 0 : 10; cyc = 0; fin = 1'b0; tog = 1'b1;
    start = 1'b1; decrypt = dec;
    step();
    start = 1'b0; decrypt = 1'($urandom_range(0, 1));
    while (!fin && cyc < 200) begin
      chk("rk_valid", rk_bus.rk_valid, 1);
      chk("busy", busy, 1);
      chk("rk_round", rk_bus.rk_round, 128'(e));
      chk("rk_data", rk_bus.rk_data, m_key[e]);
      chk("rk_last", rk_bus.rk_last, e == term);
      chk("done_mid", done, 0);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      rk_bus.rk_ready = rdy;
      if (junk) begin
        key_in_valid = 1'b1; key_in = rnd128(); key_wr_addr = 4'd3; key_wr_data = rnd128();
      end
      step();
      cyc++;
      if (rdy) begin
        if (e == term) fin = 1'b1;
        else e = dec ? e - 1 : e + 1;
      end
    end
    rk_bus.rk_ready = 1'b0; key_in_valid = 1'b0; key_wr_addr = '0;
    chk("stream_finished", fin, 1);
    if (mode == 0) chk("cycles_tied", cyc, 11);
    if (mode == 1) chk("cycles_toggle", cyc, 21);
    chk("post_valid", rk_bus.rk_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_done", done, 1);
    chk("post_keys_ready", keys_ready, 1);
  endtask

  initial begin
    fips[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    fips[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    fips[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    fips[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    fips[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    fips[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    fips[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    fips[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    fips[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    fips[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    fips[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    rk_bus.rk_ready = 1'b0;

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_rk_valid", rk_bus.rk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_keys_ready", keys_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_rk_last", rk_bus.rk_last, 0);
    chk("rst_rk_round", rk_bus.rk_round, 0);
    chk("rst_rk_data", rk_bus.rk_data, 0);
    step(); step();
    rst = 1'b0;

    // FIPS-197 schedule load
    cap(1'b1, fips[0], 0, '0, 1'b0);
    for (int r = 1; r <= 10; r++) cap(1'b0, '0, r, fips[r], 1'b0);
    cap(1'b0, '0, 0, '0, 1'b1);

    // Encrypt tied-ready, then decrypt started in the done cycle with toggling ready
    run_stream(1'b0, 0, 1'b0);
    run_stream(1'b1, 1, 1'b0);
    step();
    chk("done_one_cycle", done, 0);

    // Writes during a stream are ignored
    run_stream(1'b0, 2, 1'b1);
    step();
    chk("done_clear_junk", done, 0);
    chk("keys_ready_kept", keys_ready, 1);

    // Random reload: key + write in same cycle, out-of-range address ignored
    cap(1'b1, rnd128(), 1, rnd128(), 1'b0);
    for (int r = 2; r <= 10; r++) cap(1'b0, '0, r, rnd128(), 1'b0);
    cap(1'b0, '0, 12, rnd128(), 1'b0);
    cap(1'b0, '0, 0, '0, 1'b1);
    run_stream(1'b1, 2, 1'b0);
    step();

    // Asynchronous reset at beat round 5
    start = 1'b1; decrypt = 1'b0;
    step();
    start = 1'b0;
    rk_bus.rk_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rk_bus.rk_ready = 1'b0;
    chk("abort_round", rk_bus.rk_round, 5);
    rst = 1'b1;
    #1;
    chk("abort_rk_valid", rk_bus.rk_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_keys_ready", keys_ready, 0);
    chk("abort_done", done, 0);
    m_valid = '0; m_loaded = 1'b0;
    step();
    chk("abort_no_done", done, 0);
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_start_valid", rk_bus.rk_valid, 0);
      chk("post_rst_start_busy", busy, 0);
      step();
    end

    // Incomplete schedule: start ignored until entry 10 arrives
    cap(1'b1, rnd128(), 0, '0, 1'b0);
    for (int r = 1; r <= 9; r++) cap(1'b0, '0, r, rnd128(), 1'b0);
    cap(1'b0, '0, 0, '0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("partial_valid", rk_bus.rk_valid, 0);
      chk("partial_busy", busy, 0);
      step();
    end
    cap(1'b0, '0, 10, rnd128(), 1'b0);
    run_stream(1'b0, 2, 1'b0);
    step();
    chk("final_done_clear", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
